rv32_muldiv_unit: RTL and testbench

//   Full RV32M execute unit. Pipelined multiplier (MUL/MULH/MULHSU/MULHU) plus an

---
 rtl/rv32_muldiv_unit_pkg.sv | 23 ++
 rtl/rv32_muldiv_unit_div_iter.sv | 102 ++++++++++
 rtl/rv32_muldiv_unit.sv | 115 +++++++++++
 tb/tb_rv32_muldiv_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_muldiv_unit_pkg.sv
// Shared RV32M types for the mul/div execute unit (package rv32_types).
package rv32_types;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  localparam int unsigned DIV_ITERS = 32;

endpackage

// File: rtl/rv32_muldiv_unit_div_iter.sv
// Iterative radix-2 restoring divider (rv32_div_iter) with start/done handshake.
// Only compiled when RV32_MULDIV_DIV_EN is defined.
`ifdef RV32_MULDIV_DIV_EN
module rv32_div_iter
  import rv32_types::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        start,
  input  logic        is_signed,
  input  logic        is_rem,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        ack,
  output logic        idle,
  output logic        valid,
  output logic [31:0] result
);
  localparam int unsigned CNT_W = $clog2(DIV_ITERS);

  div_state_t       state;
  logic [31:0]      quo, rem, dvs, mag1, mag2, fixed;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r, rem_sel;
  logic [32:0]      shifted;
  logic [33:0]      diff;

  always_comb begin
    mag1    = (is_signed && dividend[31]) ? -dividend : dividend;
    mag2    = (is_signed && divisor[31])  ? -divisor  : divisor;
    shifted = {rem, quo[31]};
    diff    = {1'b0, shifted} - {2'b00, dvs};
    fixed   = rem_sel ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
  end

  assign idle = (state == DIV_IDLE);

  // DONE is entered with valid low after iterating; the fixup cycle then raises valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= DIV_IDLE;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem_sel <= 1'b0;
      valid   <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      state <= DIV_IDLE;
      valid <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          rem_sel <= is_rem;
          neg_q   <= is_signed && (dividend[31] ^ divisor[31]);
          neg_r   <= is_signed && dividend[31];
          if (divisor == '0) begin
            result <= is_rem ? dividend : '1;
            valid  <= 1'b1;
            state  <= DIV_DONE;
          end else if (is_signed && dividend == 32'h8000_0000 && divisor == '1) begin
            result <= is_rem ? '0 : 32'h8000_0000;
            valid  <= 1'b1;
            state  <= DIV_DONE;
          end else begin
            quo   <= mag1;
            rem   <= '0;
            dvs   <= mag2;
            cnt   <= '0;
            state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (!diff[33]) begin
            rem <= diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= shifted[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_ITERS - 1)) state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (!valid) begin
            result <= fixed;
            valid  <= 1'b1;
          end else if (ack) begin
            valid <= 1'b0;
            state <= DIV_IDLE;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule
`endif

// File: rtl/rv32_muldiv_unit.sv
// RV32M execute unit: stallable multiply pipe, optional iterative divider, output mux.
// Divider present only when RV32_MULDIV_DIV_EN is defined; otherwise DIV* ops return out_err.
module rv32_muldiv_unit
  import rv32_types::*;
#(
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned TAG_W      = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opsel,
  input  logic [31:0]      op1,
  input  logic [31:0]      op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  typedef struct packed {
    logic             valid;
    logic             err;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } stage_t;

  muldiv_op_t         op;
  logic               is_div, e1, e2, stall, accept, pipe_load, load_err;
  logic signed [63:0] a, b, p;
  logic [31:0]        mul_word, load_word;
  stage_t             pipe [MUL_STAGES];
  stage_t             last;

  assign op     = muldiv_op_t'(opsel);
  assign is_div = opsel[2];
  assign last   = pipe[MUL_STAGES-1];
  assign stall  = last.valid && !out_ready;
  assign accept = in_valid && in_ready;

  // One 33x33 signed product; the extension bits select signed/unsigned operands.
  always_comb begin
    e1       = (op == MD_MULH || op == MD_MULHSU) && op1[31];
    e2       = (op == MD_MULH) && op2[31];
    a        = {{32{e1}}, op1};
    b        = {{32{e2}}, op2};
    p        = a * b;
    mul_word = (op == MD_MUL) ? p[31:0] : p[63:32];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < MUL_STAGES; i++) pipe[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < MUL_STAGES; i++) pipe[i].valid <= 1'b0;
    end else if (!stall) begin
      pipe[0] <= '{valid: pipe_load, err: load_err, tag: in_tag, data: load_word};
      for (int unsigned i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

`ifdef RV32_MULDIV_DIV_EN
  logic             div_idle, div_valid, pipe_empty;
  logic [31:0]      div_result;
  logic [TAG_W-1:0] div_tag;

  always_comb begin
    pipe_empty = 1'b1;
    for (int unsigned i = 0; i < MUL_STAGES; i++) if (pipe[i].valid) pipe_empty = 1'b0;
  end

  assign in_ready  = !flush && div_idle && (is_div ? pipe_empty : !stall);
  assign pipe_load = accept && !is_div;
  assign load_word = mul_word;
  assign load_err  = 1'b0;

  rv32_div_iter u_div (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .start     (accept && is_div),
    .is_signed (!opsel[0]),
    .is_rem    (opsel[1]),
    .dividend  (op1),
    .divisor   (op2),
    .ack       (out_ready),
    .idle      (div_idle),
    .valid     (div_valid),
    .result    (div_result)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) div_tag <= '0;
    else if (accept && is_div) div_tag <= in_tag;
  end

  assign out_valid = last.valid || div_valid;
  assign result    = div_valid ? div_result : last.data;
  assign out_tag   = div_valid ? div_tag : last.tag;
  assign out_err   = div_valid ? 1'b0 : last.err;
`else
  assign in_ready  = !flush && !stall;
  assign pipe_load = accept;
  assign load_word = is_div ? '0 : mul_word;
  assign load_err  = is_div;

  assign out_valid = last.valid;
  assign result    = last.data;
  assign out_tag   = last.tag;
  assign out_err   = last.err;
`endif
endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Scoreboard bench for rv32_muldiv_unit; divider tests follow RV32_MULDIV_DIV_EN.
module tb_rv32_muldiv_unit;
  import rv32_types::*;

  localparam int unsigned STAGES = 2;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        err;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  logic        clk = 1'b0, resetn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_err;
  logic [2:0]  opsel = '0;
  logic [31:0] op1 = '0, op2 = '0, result;
  logic [4:0]  in_tag = '0, out_tag;

  int unsigned n_checks = 0, n_fail = 0, cyc = 0;
  exp_t        sb[$];

  rv32_muldiv_unit #(.MUL_STAGES(STAGES), .TAG_W(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opsel(opsel), .op1(op1), .op2(op2), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
        check("out_err", {31'd0, out_err}, {31'd0, e.err});
        if (e.lat != 0) check("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] res, input logic err,
                       input int unsigned lat, input bit push);
    int unsigned n = 0;
    exp_t e;
    opsel = op; op1 = a; op2 = b; in_tag = tag; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("accept", {31'd0, in_ready}, 32'd1);
    if (in_ready && push) begin
      e.res = res; e.tag = tag; e.err = err; e.acc = cyc; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    check("drain", sb.size(), 32'd0);
  endtask

  task automatic busy_check(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clk);
      check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned hits;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_out_tag", {27'd0, out_tag}, 32'd0);
    check("reset_out_err", {31'd0, out_err}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back multiplies, results on consecutive cycles
    issue(MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 1'b0, STAGES, 1);
    issue(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b0, STAGES, 1);
    issue(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 1'b0, STAGES, 1);
    issue(MD_MUL,    32'd7,         32'hFFFF_FFFD, 5'd4, 32'hFFFF_FFEB, 1'b0, STAGES, 1);
    drain();

`ifdef RV32_MULDIV_DIV_EN
    issue(MD_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 1'b0, 34, 1);
    busy_check(34);
    drain();
    issue(MD_REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b0, 34, 1);
    busy_check(34);
    drain();
    issue(MD_DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 1'b0, 34, 1);
    busy_check(34);
    drain();

    issue(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1'b0, 1, 1);
    issue(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h0000_0000, 1'b0, 1, 1);
    issue(MD_DIVU, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1'b0, 1, 1);
    issue(MD_REMU, 32'd5, 32'd0, 5'd11, 32'd5, 1'b0, 1, 1);
    drain();
`endif

    // Backpressure: 5 stalled cycles inside a 3-op burst
    out_ready = 1'b0;
    fork
      begin
        issue(MD_MUL, 32'd3, 32'd5,  5'd12, 32'd15, 1'b0, 0, 1);
        issue(MD_MUL, 32'd4, 32'd6,  5'd13, 32'd24, 1'b0, 0, 1);
        issue(MD_MUL, 32'd9, 32'd11, 5'd14, 32'd99, 1'b0, 0, 1);
      end
      begin
        int unsigned n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 5; i++) begin
          if (i != 0) @(negedge clk);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
          check("stall_out_valid", {31'd0, out_valid}, 32'd1);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

`ifdef RV32_MULDIV_DIV_EN
    // Flush during divider iteration 10
    issue(MD_DIV, 32'd1000, 32'd3, 5'd15, 32'd0, 1'b0, 0, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_div_in_ready", {31'd0, in_ready}, 32'd1);
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    check("flush_div_out_valid", hits, 32'd0);
    @(posedge clk); #1;
`endif

    // Flush while a mul result is held
    out_ready = 1'b0;
    issue(MD_MUL, 32'd2, 32'd2, 5'd16, 32'd4, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("held_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    out_ready = 1'b1;
    hits = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    check("flush_mul_dropped", hits, 32'd0);
    @(posedge clk); #1;
    issue(MD_MUL, 32'd6, 32'd7, 5'd17, 32'd42, 1'b0, STAGES, 1);
    drain();

`ifndef RV32_MULDIV_DIV_EN
    // Divider absent: DIV* ops return 0 with out_err through the mul pipe
    issue(MD_DIVU, 32'd9, 32'd3, 5'd18, 32'd0, 1'b1, STAGES, 1);
    issue(MD_REM,  32'd9, 32'd3, 5'd19, 32'd0, 1'b1, STAGES, 1);
    issue(MD_MUL,  32'd9, 32'd3, 5'd20, 32'd27, 1'b0, STAGES, 1);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
